ieu_operand_stage: RTL and testbench
====================================

// Module: ieu_operand_stage
// PURPOSE
//  Operand-issue stage directly upstream of the integer ALU. Accepts a decoded op plus regfile read data,
//  resolves RAW hazards by EX/WB forwarding, selects operand_1 (rs1|pc) and operand_2 (rs2|imm), and
//  presents a registered op to the ALU. Valid/ready on both sides, with a 2-entry skid buffer so in_ready is
//  registered (except for the load-use interlock).
// PARAMETERS
//  REG_ADDR_W   5              architectural register index width
//  (XLEN)       pipeline::XLEN datapath width, 32 or 64; package constant, not a parameter
// PORTS
//  clk            in   1           clock; all state updates on rising edge
//  reset          in   1           synchronous, active-high
//  flush          in   1           drop all buffered ops (branch mispredict/trap)
//  in_valid       in   1           decode presents an op
//  in_ready       out  1           stage accepts op this cycle
//  in_rs1_addr    in   REG_ADDR_W  source register 1 index
//  in_rs2_addr    in   REG_ADDR_W  source register 2 index
//  in_rs1_data    in   XLEN        regfile data for rs1
//  in_rs2_data    in   XLEN        regfile data for rs2
//  in_pc          in   XLEN        PC of op
//  in_imm         in   XLEN        sign-extended immediate
//  in_op1_sel     in   1           0: rs1, 1: pc
//  in_op2_sel     in   1           0: rs2, 1: imm
//  in_funct3      in   3           passed to ALU
//  in_funct7      in   7           passed to ALU
//  in_word        in   1           RV64 *W op flag, passed to ALU
//  in_rd_addr     in   REG_ADDR_W  destination index
//  ex_fwd_valid   in   1           op in EX writes ex_fwd_rd
//  ex_fwd_rd      in   REG_ADDR_W  EX destination index
//  ex_fwd_data    in   XLEN        EX result (ALU output)
//  ex_is_load     in   1           EX op is a load; data not yet available
//  wb_fwd_valid   in   1           op in WB writes wb_fwd_rd
//  wb_fwd_rd      in   REG_ADDR_W  WB destination index
//  wb_fwd_data    in   XLEN        WB result
//  out_valid      out  1           op presented to ALU
//  out_ready      in   1           ALU/EX accepts op
//  out_funct3     out  3           ALU control
//  out_funct7     out  7           ALU control
//  out_word       out  1           ALU control
//  out_operand_1  out  XLEN        ALU operand 1
//  out_operand_2  out  XLEN        ALU operand 2
//  out_store_data out  XLEN        forwarded rs2 value, for stores
//  out_rd_addr    out  REG_ADDR_W  destination index
// BEHAVIOUR
//  - Reset: out_valid=0, skid empty, all out_* data=0. in_ready=1 unless the load-use interlock asserts.
//  - Forwarding (combinational, at accept): per source, priority EX > WB > regfile. Index 0 is never
//    forwarded; it always reads 0.
//  - Forwarded values are final, so buffered entries are never re-forwarded.
//  - Load-use interlock: ex_fwd_valid & ex_is_load & ex_fwd_rd!=0 & rd matches a used source -> in_ready=0.
//    Sources used: rs1 when op1_sel=0; rs2 always, because store data is taken from rs2.
//  - in_ready = !skid_valid & !interlock. Accept = in_valid & in_ready.
//  - Latency: 1 cycle from accept to out_valid when the stage is empty.
//  - Main register loads when it is empty or out_ready=1. Otherwise the accepted op goes to the skid entry.
//  - On out_ready & out_valid with skid_valid: main<=skid, skid cleared, same cycle as any new accept.
//    The new accept then goes to the skid entry only if main stays occupied.
//  - Ordering is strictly FIFO; at most 2 ops in flight.
//  - flush: next cycle out_valid=0 and skid empty. flush overrides a simultaneous accept (op dropped).
//  - reset overrides flush.
//  - out_* data is held stable while out_valid & !out_ready.
// CONFIGURATION
//  IEU_FWD_EN defined: forwarding as above.
//  IEU_FWD_EN undefined: no forwarding; operands come from the regfile only. in_ready=0 whenever a used
//  source (!=0) matches ex_fwd_rd (ex_fwd_valid) or wb_fwd_rd (wb_fwd_valid). In this case the regfile
//  must write-before-read.
// STRUCTURE
//  - pipeline package: typedef ieu_op_t {funct3, funct7, word, operand_1, operand_2, store_data, rd_addr};
//    constants OP1_RS1/OP1_PC and OP2_RS2/OP2_IMM.
//  - Sub-module ieu_skid_buffer: generic 2-entry valid/ready buffer over ieu_op_t. It owns main/skid
//    registers and in_ready.
//  - The top level holds the forwarding muxes, operand select and interlock only.
// TESTING
//  1. Reset, then one op: rs1=x1 (regfile 5), imm=7, op2_sel=1 -> out_valid 1 cycle later,
//     operand_1=5, operand_2=7.
//  2. EX writes x3=0x10 and WB writes x3=0x20; op reads x3 -> operand_1=0x10 (EX wins).
//     Op reading x0 with EX rd=0 -> 0.
//  3. ex_is_load with rd=x4; op uses rs1=x4 -> in_ready=0 while asserted. Drop ex_is_load, WB x4=9
//     -> accepted, operand_1=9.
//  4. Hold out_ready=0, drive 3 back-to-back ops A,B,C -> A,B accepted, in_ready=0 on C.
//     Release -> A,B,C emerge in order with no loss or duplication.
//  5. Two ops buffered, flush asserted with in_valid=1 -> next cycle out_valid=0, the new op is dropped,
//     in_ready=1.
//  6. Build without IEU_FWD_EN: WB rd=x2 pending, op reads x2 -> stalls until wb_fwd_valid=0,
//     then accepted with regfile value.

Source files
------------

// File: rtl/pipeline.sv
// Shared integer-pipeline types: datapath width, operand-select encodings and the
// operand-stage payload handed to the ALU, plus the bypass-priority helper.
package pipeline;

   localparam int XLEN       = 32;
   localparam int ARCH_REG_W = 5;

   localparam logic OP1_RS1 = 1'b0;
   localparam logic OP1_PC  = 1'b1;
   localparam logic OP2_RS2 = 1'b0;
   localparam logic OP2_IMM = 1'b1;

   typedef struct packed {
      logic [2:0]            funct3;
      logic [6:0]            funct7;
      logic                  word;
      logic [XLEN-1:0]       operand_1;
      logic [XLEN-1:0]       operand_2;
      logic [XLEN-1:0]       store_data;
      logic [ARCH_REG_W-1:0] rd_addr;
   } ieu_op_t;

   // x0 is hard-wired to zero; the younger EX result shadows the older WB result.
   function automatic logic [XLEN-1:0] fwd_select(
      input logic [ARCH_REG_W-1:0] src,
      input logic [XLEN-1:0]       rf_data,
      input logic                  ex_valid,
      input logic [ARCH_REG_W-1:0] ex_rd,
      input logic [XLEN-1:0]       ex_data,
      input logic                  wb_valid,
      input logic [ARCH_REG_W-1:0] wb_rd,
      input logic [XLEN-1:0]       wb_data
   );
      if (src == '0)                    return '0;
      if (ex_valid && (ex_rd == src))   return ex_data;
      if (wb_valid && (wb_rd == src))   return wb_data;
      return rf_data;
   endfunction

endpackage

// File: rtl/ieu_skid_buffer.sv
// Two-entry valid/ready buffer: a main register facing the consumer and a skid entry
// that absorbs one op while the consumer stalls, so in_ready comes straight from a flop.
module ieu_skid_buffer
   import pipeline::*;
#(
   parameter type T = ieu_op_t
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   logic main_valid_q, main_valid_d;
   logic skid_valid_q, skid_valid_d;
   T     main_q, main_d;
   T     skid_q, skid_d;
   logic push;

   assign in_ready = !skid_valid_q;
   assign push     = in_valid && !skid_valid_q;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the block infers a latch.
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_ready) begin
         // Main is free this cycle: the older skid op has priority over a new arrival.
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = push;
            if (push) main_d = in_data;
         end
      end else if (push) begin
         skid_d       = in_data;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses <= so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         // NOTE: payload flops are reset as well because the ALU-facing data must read zero out of reset.
         main_q       <= '0;
         skid_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_data  = main_q;

endmodule

// File: rtl/ieu_operand_stage.sv
// Operand-issue stage ahead of the integer ALU: hazard resolution, operand select and a skid buffer.
// IEU_FWD_EN defined: EX/WB bypass with load-use interlock; undefined: stall on any pending writer.
module ieu_operand_stage
   import pipeline::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] in_rs1_addr,
   input  logic [REG_ADDR_W-1:0] in_rs2_addr,
   input  logic [XLEN-1:0]       in_rs1_data,
   input  logic [XLEN-1:0]       in_rs2_data,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [XLEN-1:0]       in_imm,
   input  logic                  in_op1_sel,
   input  logic                  in_op2_sel,
   input  logic [2:0]            in_funct3,
   input  logic [6:0]            in_funct7,
   input  logic                  in_word,
   input  logic [REG_ADDR_W-1:0] in_rd_addr,
   input  logic                  ex_fwd_valid,
   input  logic [REG_ADDR_W-1:0] ex_fwd_rd,
   input  logic [XLEN-1:0]       ex_fwd_data,
   input  logic                  ex_is_load,
   input  logic                  wb_fwd_valid,
   input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
   input  logic [XLEN-1:0]       wb_fwd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2:0]            out_funct3,
   output logic [6:0]            out_funct7,
   output logic                  out_word,
   output logic [XLEN-1:0]       out_operand_1,
   output logic [XLEN-1:0]       out_operand_2,
   output logic [XLEN-1:0]       out_store_data,
   output logic [REG_ADDR_W-1:0] out_rd_addr
);

   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            rs1_used, rs2_used;
   logic            ex_hit, interlock, buf_in_ready;
   ieu_op_t         op_in, op_out;

   // rs2 is always live because stores take their data from it.
   assign rs1_used = (in_op1_sel == OP1_RS1) && (in_rs1_addr != '0);
   assign rs2_used = (in_rs2_addr != '0);

   assign ex_hit = ex_fwd_valid && (ex_fwd_rd != '0) &&
                   ((rs1_used && (ex_fwd_rd == in_rs1_addr)) ||
                    (rs2_used && (ex_fwd_rd == in_rs2_addr)));

`ifdef IEU_FWD_EN
   assign rs1_val = fwd_select(ARCH_REG_W'(in_rs1_addr), in_rs1_data,
                               ex_fwd_valid, ARCH_REG_W'(ex_fwd_rd), ex_fwd_data,
                               wb_fwd_valid, ARCH_REG_W'(wb_fwd_rd), wb_fwd_data);
   assign rs2_val = fwd_select(ARCH_REG_W'(in_rs2_addr), in_rs2_data,
                               ex_fwd_valid, ARCH_REG_W'(ex_fwd_rd), ex_fwd_data,
                               wb_fwd_valid, ARCH_REG_W'(wb_fwd_rd), wb_fwd_data);
   assign interlock = ex_hit && ex_is_load;
`else
   logic wb_hit;
   logic unused_fwd;

   assign wb_hit = wb_fwd_valid && (wb_fwd_rd != '0) &&
                   ((rs1_used && (wb_fwd_rd == in_rs1_addr)) ||
                    (rs2_used && (wb_fwd_rd == in_rs2_addr)));
   assign rs1_val    = (in_rs1_addr == '0) ? '0 : in_rs1_data;
   assign rs2_val    = (in_rs2_addr == '0) ? '0 : in_rs2_data;
   assign interlock  = ex_hit || wb_hit;
   assign unused_fwd = ^{ex_is_load, ex_fwd_data, wb_fwd_data};
`endif

   assign op_in = '{
      funct3:     in_funct3,
      funct7:     in_funct7,
      word:       in_word,
      operand_1:  (in_op1_sel == OP1_PC)  ? in_pc  : rs1_val,
      operand_2:  (in_op2_sel == OP2_IMM) ? in_imm : rs2_val,
      store_data: rs2_val,
      rd_addr:    ARCH_REG_W'(in_rd_addr)
   };

   ieu_skid_buffer #(.T(ieu_op_t)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid && !interlock),
      .in_ready  (buf_in_ready),
      .in_data   (op_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (op_out)
   );

   assign in_ready       = buf_in_ready && !interlock;
   assign out_funct3     = op_out.funct3;
   assign out_funct7     = op_out.funct7;
   assign out_word       = op_out.word;
   assign out_operand_1  = op_out.operand_1;
   assign out_operand_2  = op_out.operand_2;
   assign out_store_data = op_out.store_data;
   assign out_rd_addr    = REG_ADDR_W'(op_out.rd_addr);

endmodule

// File: tb/tb_ieu_operand_stage.sv
// Self-checking bench for ieu_operand_stage: directed vector table, hand-built FIFO/flush
// sequences and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_ieu_operand_stage;
   import pipeline::*;

   localparam int RW = 5;
   typedef logic [XLEN-1:0] word_t;

   typedef struct {
      logic valid;
      logic [RW-1:0] rs1, rs2, rd;
      word_t rs1_data, rs2_data, pc, imm;
      logic op1_sel, op2_sel;
      logic [2:0] f3;
      logic [6:0] f7;
      logic word;
      logic ex_v;
      logic [RW-1:0] ex_rd;
      word_t ex_d;
      logic ex_load;
      logic wb_v;
      logic [RW-1:0] wb_rd;
      word_t wb_d;
   } stim_t;

   typedef struct {
      word_t op1, op2, sd;
      logic [2:0] f3;
      logic [6:0] f7;
      logic word;
      logic [RW-1:0] rd;
   } exp_op_t;

   typedef struct {
      stim_t s;
      logic  ready;
      word_t op1, op2, sd;
   } vec_t;

   logic clk, reset, flush, in_valid, in_ready;
   logic [RW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr, ex_fwd_rd, wb_fwd_rd, out_rd_addr;
   word_t in_rs1_data, in_rs2_data, in_pc, in_imm, ex_fwd_data, wb_fwd_data;
   logic in_op1_sel, in_op2_sel, in_word, ex_fwd_valid, ex_is_load, wb_fwd_valid;
   logic [2:0] in_funct3, out_funct3;
   logic [6:0] in_funct7, out_funct7;
   logic out_valid, out_ready, out_word;
   word_t out_operand_1, out_operand_2, out_store_data;

   int n_pass = 0;
   int n_total = 0;
   exp_op_t q[$];
   vec_t tbl[8];

   ieu_operand_stage #(.REG_ADDR_W(RW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_pc(in_pc), .in_imm(in_imm), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_word(in_word), .in_rd_addr(in_rd_addr),
      .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
      .ex_is_load(ex_is_load),
      .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_word(out_word),
      .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
      .out_store_data(out_store_data), .out_rd_addr(out_rd_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic word_t w(input int unsigned v);
      return word_t'(v);
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic stim_t mk(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                                input word_t d1, input word_t d2,
                                input logic s1, input logic s2);
      stim_t s;
      s = idle();
      s.valid = 1'b1;
      s.rs1 = rs1; s.rs2 = rs2; s.rs1_data = d1; s.rs2_data = d2;
      s.op1_sel = s1; s.op2_sel = s2;
      s.pc = w('h100); s.imm = w(7); s.rd = 5'd10;
      s.f3 = 3'd5; s.f7 = 7'h20; s.word = 1'b0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.valid    = ($urandom_range(9, 0) < 7);
      s.rs1      = RW'($urandom_range(7, 0));
      s.rs2      = RW'($urandom_range(7, 0));
      s.rd       = RW'($urandom_range(31, 0));
      s.rs1_data = word_t'({$urandom, $urandom});
      s.rs2_data = word_t'({$urandom, $urandom});
      s.pc       = word_t'({$urandom, $urandom});
      s.imm      = word_t'({$urandom, $urandom});
      s.op1_sel  = 1'($urandom_range(1, 0));
      s.op2_sel  = 1'($urandom_range(1, 0));
      s.f3       = 3'($urandom);
      s.f7       = 7'($urandom);
      s.word     = 1'($urandom);
      s.ex_v     = 1'($urandom_range(1, 0));
      s.ex_rd    = RW'($urandom_range(7, 0));
      s.ex_d     = word_t'({$urandom, $urandom});
      s.ex_load  = ($urandom_range(3, 0) == 0);
      s.wb_v     = 1'($urandom_range(1, 0));
      s.wb_rd    = RW'($urandom_range(7, 0));
      s.wb_d     = word_t'({$urandom, $urandom});
      return s;
   endfunction

   // Reference: value a source register resolves to for this op (second=1 selects rs2).
   function automatic word_t src_val(input stim_t s, input logic second);
      logic [RW-1:0] a;
      word_t rf;
      a  = second ? s.rs2 : s.rs1;
      rf = second ? s.rs2_data : s.rs1_data;
      if (a == '0) return '0;
`ifdef IEU_FWD_EN
      if (s.ex_v && s.ex_rd == a) return s.ex_d;
      if (s.wb_v && s.wb_rd == a) return s.wb_d;
`endif
      return rf;
   endfunction

   // Reference: the op must wait because a live source is not yet obtainable.
   function automatic logic blocked(input stim_t s);
      logic [RW-1:0] src [2];
      logic hit;
      hit    = 1'b0;
      src[0] = s.rs2;
      src[1] = (s.op1_sel == 1'b0) ? s.rs1 : '0;
      for (int i = 0; i < 2; i++) begin
         if (src[i] != '0) begin
`ifdef IEU_FWD_EN
            if (s.ex_v && s.ex_load && s.ex_rd == src[i]) hit = 1'b1;
`else
            if ((s.ex_v && s.ex_rd == src[i]) || (s.wb_v && s.wb_rd == src[i])) hit = 1'b1;
`endif
         end
      end
      return hit;
   endfunction

   function automatic exp_op_t expect_op(input stim_t s);
      exp_op_t e;
      e.op1  = s.op1_sel ? s.pc  : src_val(s, 1'b0);
      e.op2  = s.op2_sel ? s.imm : src_val(s, 1'b1);
      e.sd   = src_val(s, 1'b1);
      e.f3   = s.f3;
      e.f7   = s.f7;
      e.word = s.word;
      e.rd   = s.rd;
      return e;
   endfunction

   task automatic drive(input stim_t s);
      in_valid = s.valid; in_rs1_addr = s.rs1; in_rs2_addr = s.rs2; in_rd_addr = s.rd;
      in_rs1_data = s.rs1_data; in_rs2_data = s.rs2_data; in_pc = s.pc; in_imm = s.imm;
      in_op1_sel = s.op1_sel; in_op2_sel = s.op2_sel;
      in_funct3 = s.f3; in_funct7 = s.f7; in_word = s.word;
      ex_fwd_valid = s.ex_v; ex_fwd_rd = s.ex_rd; ex_fwd_data = s.ex_d; ex_is_load = s.ex_load;
      wb_fwd_valid = s.wb_v; wb_fwd_rd = s.wb_rd; wb_fwd_data = s.wb_d;
   endtask

   // One cycle from a negedge: drive, compare against the model, clock, update the model.
   task automatic step(input stim_t s, input logic rdy, input logic fl, input string tag);
      logic exp_ready;
      drive(s);
      out_ready = rdy;
      flush     = fl;
      #1;
      exp_ready = (q.size() < 2) && !blocked(s);
      check($sformatf("%s.in_ready", tag), 64'(in_ready), 64'(exp_ready));
      check($sformatf("%s.out_valid", tag), 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check($sformatf("%s.operand_1", tag), 64'(out_operand_1), 64'(q[0].op1));
         check($sformatf("%s.operand_2", tag), 64'(out_operand_2), 64'(q[0].op2));
         check($sformatf("%s.store_data", tag), 64'(out_store_data), 64'(q[0].sd));
         check($sformatf("%s.funct3", tag), 64'(out_funct3), 64'(q[0].f3));
         check($sformatf("%s.funct7", tag), 64'(out_funct7), 64'(q[0].f7));
         check($sformatf("%s.word", tag), 64'(out_word), 64'(q[0].word));
         check($sformatf("%s.rd_addr", tag), 64'(out_rd_addr), 64'(q[0].rd));
      end
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (rdy && q.size() != 0) void'(q.pop_front());
         if (s.valid && exp_ready) q.push_back(expect_op(s));
      end
      @(negedge clk);
   endtask

   initial begin
      stim_t b, a_op, b_op, c_op;

      // Directed vectors, each applied to an empty stage with out_ready=1.
      b = mk(5'd1, 5'd2, w(5), w('h22), 1'b0, 1'b1);
      tbl[0] = '{s: b, ready: 1'b1, op1: w(5), op2: w(7), sd: w('h22)};

      b = mk(5'd3, 5'd0, w('h30), w(0), 1'b0, 1'b1);
      b.imm = w(1);
      b.ex_v = 1'b1; b.ex_rd = 5'd3; b.ex_d = w('h10);
      b.wb_v = 1'b1; b.wb_rd = 5'd3; b.wb_d = w('h20);
`ifdef IEU_FWD_EN
      tbl[1] = '{s: b, ready: 1'b1, op1: w('h10), op2: w(1), sd: w(0)};
`else
      tbl[1] = '{s: b, ready: 1'b0, op1: w(0), op2: w(0), sd: w(0)};
`endif

      b = mk(5'd0, 5'd0, w(0), w(0), 1'b0, 1'b0);
      b.ex_v = 1'b1; b.ex_rd = 5'd0; b.ex_d = w('hdead);
      b.wb_v = 1'b1; b.wb_rd = 5'd0; b.wb_d = w('hbeef);
      tbl[2] = '{s: b, ready: 1'b1, op1: w(0), op2: w(0), sd: w(0)};

      b = mk(5'd6, 5'd5, w('h66), w('h50), 1'b0, 1'b0);
      b.wb_v = 1'b1; b.wb_rd = 5'd5; b.wb_d = w('h55);
      b.ex_v = 1'b1; b.ex_rd = 5'd7; b.ex_d = w('h77);
`ifdef IEU_FWD_EN
      tbl[3] = '{s: b, ready: 1'b1, op1: w('h66), op2: w('h55), sd: w('h55)};
`else
      tbl[3] = '{s: b, ready: 1'b0, op1: w(0), op2: w(0), sd: w(0)};
`endif

      b = mk(5'd4, 5'd0, w('h40), w(0), 1'b0, 1'b1);
      b.ex_v = 1'b1; b.ex_rd = 5'd4; b.ex_load = 1'b1; b.ex_d = w('hbad);
      tbl[4] = '{s: b, ready: 1'b0, op1: w(0), op2: w(0), sd: w(0)};

      b = mk(5'd4, 5'd9, w('h40), w('h99), 1'b1, 1'b0);
      b.pc = w('h200);
      b.ex_v = 1'b1; b.ex_rd = 5'd4; b.ex_load = 1'b1; b.ex_d = w('hbad);
      tbl[5] = '{s: b, ready: 1'b1, op1: w('h200), op2: w('h99), sd: w('h99)};

      b = mk(5'd0, 5'd4, w(0), w('h40), 1'b1, 1'b1);
      b.ex_v = 1'b1; b.ex_rd = 5'd4; b.ex_load = 1'b1; b.ex_d = w('hbad);
      tbl[6] = '{s: b, ready: 1'b0, op1: w(0), op2: w(0), sd: w(0)};

      b = mk(5'd8, 5'd8, w('h80), w('h80), 1'b0, 1'b0);
      b.ex_v = 1'b1; b.ex_rd = 5'd8; b.ex_d = w('h81);
`ifdef IEU_FWD_EN
      tbl[7] = '{s: b, ready: 1'b1, op1: w('h81), op2: w('h81), sd: w('h81)};
`else
      tbl[7] = '{s: b, ready: 1'b0, op1: w(0), op2: w(0), sd: w(0)};
`endif

      // Reset
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(idle());
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset.in_ready", 64'(in_ready), 64'(1'b1));
      check("reset.out_valid", 64'(out_valid), 64'(1'b0));
      check("reset.operand_1", 64'(out_operand_1), 64'(0));
      check("reset.operand_2", 64'(out_operand_2), 64'(0));
      check("reset.store_data", 64'(out_store_data), 64'(0));
      check("reset.rd_addr", 64'(out_rd_addr), 64'(0));
      @(negedge clk);

      foreach (tbl[i]) begin
         drive(tbl[i].s);
         out_ready = 1'b1;
         flush     = 1'b0;
         #1;
         check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(tbl[i].ready));
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].ready));
         if (tbl[i].ready) begin
            check($sformatf("vec%0d.operand_1", i), 64'(out_operand_1), 64'(tbl[i].op1));
            check($sformatf("vec%0d.operand_2", i), 64'(out_operand_2), 64'(tbl[i].op2));
            check($sformatf("vec%0d.store_data", i), 64'(out_store_data), 64'(tbl[i].sd));
         end
         @(negedge clk);
      end
      drive(idle());

      // Stall until the pending source is obtainable, then accept with the right value.
`ifdef IEU_FWD_EN
      b = mk(5'd4, 5'd0, w('h40), w(0), 1'b0, 1'b1);
      b.ex_v = 1'b1; b.ex_rd = 5'd4; b.ex_load = 1'b1; b.ex_d = w('hbad);
      repeat (3) step(b, 1'b1, 1'b0, "lu_hold");
      check("lu_hold.in_ready_low", 64'(in_ready), 64'(1'b0));
      b.ex_v = 1'b0; b.ex_load = 1'b0;
      b.wb_v = 1'b1; b.wb_rd = 5'd4; b.wb_d = w(9);
      step(b, 1'b1, 1'b0, "lu_go");
      check("lu_go.operand_1_is_9", 64'(out_operand_1), 64'(9));
`else
      b = mk(5'd2, 5'd0, w('h2a), w(0), 1'b0, 1'b1);
      b.wb_v = 1'b1; b.wb_rd = 5'd2; b.wb_d = w('h77);
      repeat (3) step(b, 1'b1, 1'b0, "wb_hold");
      check("wb_hold.in_ready_low", 64'(in_ready), 64'(1'b0));
      b.wb_v = 1'b0;
      step(b, 1'b1, 1'b0, "wb_go");
      check("wb_go.operand_1_regfile", 64'(out_operand_1), 64'('h2a));
`endif
      step(idle(), 1'b1, 1'b0, "drain0");

      // Back-pressure: A, B buffered, C refused, then all three leave in order.
      a_op = mk(5'd1, 5'd2, w('hA1), w('hA2), 1'b0, 1'b0); a_op.rd = 5'd11;
      b_op = mk(5'd1, 5'd2, w('hB1), w('hB2), 1'b0, 1'b0); b_op.rd = 5'd12;
      c_op = mk(5'd1, 5'd2, w('hC1), w('hC2), 1'b0, 1'b0); c_op.rd = 5'd13;
      step(a_op, 1'b0, 1'b0, "fifo_a");
      step(b_op, 1'b0, 1'b0, "fifo_b");
      step(c_op, 1'b0, 1'b0, "fifo_c");
      check("fifo_c.refused", 64'(in_ready), 64'(1'b0));
      check("fifo_c.head_is_a", 64'(out_operand_1), 64'('hA1));
      step(c_op, 1'b1, 1'b0, "fifo_pop_a");
      step(c_op, 1'b1, 1'b0, "fifo_pop_b");
      step(idle(), 1'b1, 1'b0, "fifo_pop_c");
      step(idle(), 1'b1, 1'b0, "fifo_empty");

      // Flush with two ops buffered, then flush racing an accept.
      step(a_op, 1'b0, 1'b0, "fl_a");
      step(b_op, 1'b0, 1'b0, "fl_b");
      step(c_op, 1'b0, 1'b1, "fl_full");
      check("fl_full.out_valid", 64'(out_valid), 64'(1'b0));
      check("fl_full.in_ready", 64'(in_ready), 64'(1'b1));
      step(a_op, 1'b0, 1'b0, "fl2_a");
      step(b_op, 1'b0, 1'b1, "fl2_acc");
      step(idle(), 1'b1, 1'b0, "fl2_after");

      // Randomized traffic against the model.
      repeat (800) step(rand_stim(), ($urandom_range(9, 0) < 7), ($urandom_range(31, 0) == 0), "rand");

      // Reset takes precedence over flush and clears the payload.
      b = rand_stim();
      b.valid = 1'b1;
      drive(b);
      flush = 1'b1; reset = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; flush = 1'b0;
      drive(idle());
      q.delete();
      #1;
      check("rst2.out_valid", 64'(out_valid), 64'(1'b0));
      check("rst2.in_ready", 64'(in_ready), 64'(1'b1));
      check("rst2.operand_1", 64'(out_operand_1), 64'(0));
      check("rst2.store_data", 64'(out_store_data), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
